// File: rtl/serial_port_router.sv
// Bit-serial packet router: start bit, MSB-first port address and length, then
// data bits steered combinationally onto the addressed output port.
module serial_port_router #(
   parameter int unsigned NPORTS = 4,
   parameter int unsigned LEN_W  = 4,
   localparam int unsigned ADDR_W = $clog2(NPORTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              ser_in,
   input  logic              abort,
   output logic [NPORTS-1:0] p,
   output logic [ADDR_W-1:0] port_num,
   output logic [LEN_W-1:0]  dcnt,
   output logic              busy,
   output logic              done
);

   localparam int unsigned MAX_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
   localparam int unsigned CNT_W = $clog2(MAX_W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bcnt_q, bcnt_d;
   logic [ADDR_W-1:0]   port_num_q, port_num_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    dcnt_q, dcnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         bcnt_q     <= '0;
         port_num_q <= '0;
         len_q      <= '0;
         dcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         bcnt_q     <= bcnt_d;
         port_num_q <= port_num_d;
         len_q      <= len_d;
         dcnt_q     <= dcnt_d;
      end
   end

   // Abort overrides everything; otherwise bit-level progress only on strobes.
   always_comb begin
      state_d    = state_q;
      bcnt_d     = bcnt_q;
      port_num_d = port_num_q;
      len_d      = len_q;
      dcnt_d     = dcnt_q;
      if (abort) begin
         state_d = S_IDLE;
         bcnt_d  = '0;
         dcnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (clk_en && !ser_in) begin
                  state_d = S_ADDR;
                  bcnt_d  = '0;
               end
            end
            S_ADDR: begin
               if (clk_en) begin
                  port_num_d = ADDR_W'({port_num_q, ser_in});
                  if (bcnt_q == CNT_W'(ADDR_W - 1)) begin
                     state_d = S_LEN;
                     bcnt_d  = '0;
                  end else begin
                     bcnt_d = bcnt_q + CNT_W'(1);
                  end
               end
            end
            S_LEN: begin
               if (clk_en) begin
                  len_d = LEN_W'({len_q, ser_in});
                  if (bcnt_q == CNT_W'(LEN_W - 1)) begin
                     dcnt_d  = len_d;
                     state_d = (len_d != '0) ? S_DATA : S_DONE;
                     bcnt_d  = '0;
                  end else begin
                     bcnt_d = bcnt_q + CNT_W'(1);
                  end
               end
            end
            S_DATA: begin
               // A zero count here is unreachable; fall out rather than wrap.
               if (dcnt_q == '0) begin
                  state_d = S_DONE;
               end else if (clk_en) begin
                  dcnt_d = dcnt_q - LEN_W'(1);
                  if (dcnt_q == LEN_W'(1)) begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Data bits pass straight through to the addressed port while in DATA.
   always_comb begin
      p = '0;
      if (state_q == S_DATA) begin
         p[port_num_q] = ser_in;
      end
   end

   assign port_num = port_num_q;
   assign dcnt     = dcnt_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_port_router.sv
// Scoreboarded bench for serial_port_router: default 4-port instance plus an
// 8-port / 5-bit-length instance, driven in separate phases on one clock.
module tb_serial_port_router;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       en_a, ser_a, abort_a;
   logic [3:0] p_a;
   logic [1:0] port_a;
   logic [3:0] dcnt_a;
   logic       busy_a, done_a;

   logic       en_b, ser_b, abort_b;
   logic [7:0] p_b;
   logic [2:0] port_b;
   logic [4:0] dcnt_b;
   logic       busy_b, done_b;

   serial_port_router u_dut_a (
      .clk(clk), .rst(rst), .clk_en(en_a), .ser_in(ser_a), .abort(abort_a),
      .p(p_a), .port_num(port_a), .dcnt(dcnt_a), .busy(busy_a), .done(done_a)
   );

   serial_port_router #(.NPORTS(8), .LEN_W(5)) u_dut_b (
      .clk(clk), .rst(rst), .clk_en(en_b), .ser_in(ser_b), .abort(abort_b),
      .p(p_b), .port_num(port_b), .dcnt(dcnt_b), .busy(busy_b), .done(done_b)
   );

   typedef struct packed {
      logic [3:0] p;
      logic [1:0] port;
      logic [3:0] dcnt;
      logic       busy;
      logic       done;
   } exp_a_t;

   typedef struct packed {
      logic [7:0] p;
      logic [4:0] dcnt;
      logic       busy;
      logic       done;
   } exp_b_t;

   exp_a_t qa[$];
   exp_b_t qb[$];
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs expected during it.
   task automatic cyc_a(input logic en, input logic b, input logic ab,
                        input logic [3:0] ep, input logic [1:0] eport,
                        input logic [3:0] edc, input logic ebusy, input logic edone);
      exp_a_t e;
      @(posedge clk);
      #1;
      en_a = en; ser_a = b; abort_a = ab;
      e = '{p: ep, port: eport, dcnt: edc, busy: ebusy, done: edone};
      qa.push_back(e);
   endtask

   task automatic cyc_b(input logic en, input logic b, input logic [7:0] ep,
                        input logic [4:0] edc, input logic ebusy, input logic edone);
      exp_b_t e;
      @(posedge clk);
      #1;
      en_b = en; ser_b = b;
      e = '{p: ep, dcnt: edc, busy: ebusy, done: edone};
      qb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_a_t e;
      if (qa.size() > 0) begin
         e = qa.pop_front();
         chk("a_p", 32'(p_a), 32'(e.p));
         chk("a_port", 32'(port_a), 32'(e.port));
         chk("a_dcnt", 32'(dcnt_a), 32'(e.dcnt));
         chk("a_busy", 32'(busy_a), 32'(e.busy));
         chk("a_done", 32'(done_a), 32'(e.done));
      end
   end

   always @(negedge clk) begin
      exp_b_t e;
      if (qb.size() > 0) begin
         e = qb.pop_front();
         chk("b_p", 32'(p_b), 32'(e.p));
         chk("b_dcnt", 32'(dcnt_b), 32'(e.dcnt));
         chk("b_busy", 32'(busy_b), 32'(e.busy));
         chk("b_done", 32'(done_b), 32'(e.done));
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() > 0 || qb.size() > 0) && n < 20) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 32'(qa.size() + qb.size()), 32'd0);
   endtask

   initial begin
      logic b;
      rst = 1'b0;
      en_a = 1'b0; ser_a = 1'b1; abort_a = 1'b0;
      en_b = 1'b0; ser_b = 1'b1; abort_b = 1'b0;
      #2;
      chk("rst_p", 32'(p_a), 32'd0);
      chk("rst_port", 32'(port_a), 32'd0);
      chk("rst_dcnt", 32'(dcnt_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_b_busy", 32'(busy_b), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Basic packet: port 2, length 3, with a strobe gap inside DATA.
      cyc_a(1, 0, 0, 4'h0, 2'd0, 4'd0, 0, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd0, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h4, 2'd2, 4'd3, 1, 0);
      cyc_a(0, 1, 0, 4'h4, 2'd2, 4'd2, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd2, 1, 0);
      cyc_a(1, 1, 0, 4'h4, 2'd2, 4'd1, 1, 0);
      cyc_a(0, 1, 0, 4'h0, 2'd2, 4'd0, 1, 1);
      cyc_a(0, 0, 0, 4'h0, 2'd2, 4'd0, 0, 0);

      // Zero length straight to DONE; a strobed 0 during DONE is not a start.
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd0, 0, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd0, 4'd0, 1, 0);
      for (int i = 0; i < 4; i++) cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 1, 1);

      // Back-to-back: start on the first strobe after DONE, port 3, length 1.
      cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 0, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h8, 2'd3, 4'd1, 1, 0);
      cyc_a(0, 0, 0, 4'h0, 2'd3, 4'd0, 1, 1);
      cyc_a(0, 0, 0, 4'h0, 2'd3, 4'd0, 0, 0);

      // Abort in IDLE blocks a start; abort in DATA with dcnt=5 and a strobe.
      cyc_a(1, 0, 1, 4'h0, 2'd3, 4'd0, 0, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd3, 4'd0, 0, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 1, 1, 4'h2, 2'd1, 4'd5, 1, 0);
      cyc_a(0, 0, 0, 4'h0, 2'd1, 4'd0, 0, 0);
      cyc_a(0, 0, 0, 4'h0, 2'd1, 4'd0, 0, 0);

      // Reset asserted during LEN.
      cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 0, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd3, 4'd0, 1, 0);
      @(posedge clk);
      #1;
      en_a = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_port", 32'(port_a), 32'd0);
      chk("mid_rst_dcnt", 32'(dcnt_a), 32'd0);
      chk("mid_rst_busy", 32'(busy_a), 32'd0);
      chk("mid_rst_done", 32'(done_a), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Post-reset packet with strobe gaps: port 2, length 1, data 0.
      cyc_a(0, 0, 0, 4'h0, 2'd0, 4'd0, 0, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd0, 4'd0, 0, 0);
      cyc_a(0, 1, 0, 4'h0, 2'd0, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd0, 4'd0, 1, 0);
      cyc_a(0, 0, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd1, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(0, 1, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(1, 1, 0, 4'h0, 2'd2, 4'd0, 1, 0);
      cyc_a(0, 1, 0, 4'h4, 2'd2, 4'd1, 1, 0);
      cyc_a(1, 0, 0, 4'h0, 2'd2, 4'd1, 1, 0);
      cyc_a(0, 0, 0, 4'h0, 2'd2, 4'd0, 1, 1);
      cyc_a(0, 0, 0, 4'h0, 2'd2, 4'd0, 0, 0);
      drain();

      // Wide instance: port 5, length 17, random data with one strobe gap.
      cyc_b(1, 0, 8'h00, 5'd0, 0, 0);
      cyc_b(1, 1, 8'h00, 5'd0, 1, 0);
      cyc_b(1, 0, 8'h00, 5'd0, 1, 0);
      cyc_b(1, 1, 8'h00, 5'd0, 1, 0);
      cyc_b(1, 1, 8'h00, 5'd0, 1, 0);
      cyc_b(1, 0, 8'h00, 5'd0, 1, 0);
      cyc_b(1, 0, 8'h00, 5'd0, 1, 0);
      cyc_b(1, 0, 8'h00, 5'd0, 1, 0);
      cyc_b(1, 1, 8'h00, 5'd0, 1, 0);
      for (int i = 0; i < 17; i++) begin
         if (i == 8) cyc_b(0, 1, 8'h20, 5'(17 - i), 1, 0);
         b = 1'($urandom_range(0, 1));
         cyc_b(1, b, b ? 8'h20 : 8'h00, 5'(17 - i), 1, 0);
      end
      cyc_b(0, 1, 8'h00, 5'd0, 1, 1);
      cyc_b(0, 0, 8'h00, 5'd0, 0, 0);
      drain();
      chk("b_port_final", 32'(port_b), 32'd5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
